// File: rtl/video_pkg.sv
// Shared definitions for the idle/test-screen video source: pattern
// encoding, default raster timing and the band triangle shaper.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BAND  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_NOISE = 2'd3
  } mode_e;

  localparam int DEF_H_TOTAL    = 640;
  localparam int DEF_HB_START   = 310;
  localparam int DEF_HB_END     = 420;
  localparam int DEF_HS_START   = 336;
  localparam int DEF_HS_END     = 368;
  localparam int DEF_V_TOTAL    = 312;
  localparam int DEF_VB_START   = 306;
  localparam int DEF_VB_END     = 2;
  localparam int DEF_VS_START   = 308;
  localparam int DEF_VS_END     = 0;
  localparam int DEF_COLOR_W    = 6;
  localparam int DEF_BAR_W      = 80;
  localparam int DEF_PHASE_STEP = 6;

  // Folds a 10-bit ramp into a 9-bit up/down triangle.
  function automatic logic [8:0] triangle(input logic [9:0] idx);
    return idx[9] ? ~idx[8:0] : idx[8:0];
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR noise source; default taps give a maximal-length 23-bit sequence.
module lfsr_galois #(
  parameter int               WIDTH = 23,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(23'h42_0000),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)   state <= SEED;
    else if (en) state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/idle_screen_gen.sv
// Idle/test-screen source: raster timing, frame-synchronous pattern select
// with per-frame fade-in, and registered sync/blank/de/rgb outputs.
module idle_screen_gen
  import video_pkg::*;
#(
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int HB_START   = DEF_HB_START,
  parameter int HB_END     = DEF_HB_END,
  parameter int HS_START   = DEF_HS_START,
  parameter int HS_END     = DEF_HS_END,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int VB_START   = DEF_VB_START,
  parameter int VB_END     = DEF_VB_END,
  parameter int VS_START   = DEF_VS_START,
  parameter int VS_END     = DEF_VS_END,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int BAR_W      = DEF_BAR_W,
  parameter int PHASE_STEP = DEF_PHASE_STEP
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic [1:0]         mode,
  output logic               hs,
  output logic               vs,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start
);

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int BCW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0]      hc;
  logic [VW-1:0]      vc;
  logic [2:0]         bar;
  logic [BCW-1:0]     bcnt;
  logic               first;
  logic [9:0]         phase;
  logic [COLOR_W-1:0] lvl;
  mode_e              act_mode;
  logic [22:0]        noise;
  logic               fs_ev;

  lfsr_galois #(.WIDTH(23)) u_lfsr (
    .pclk  (pclk),
    .reset (reset),
    .en    (1'b1),
    .state (noise)
  );

  // The release cycle sits at (0,0) but is not treated as a frame boundary.
  assign fs_ev = (hc == '0) && (vc == '0) && !first;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hc    <= '0;
      vc    <= '0;
      bar   <= '0;
      bcnt  <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (hc == HW'(H_TOTAL - 1)) begin
        hc   <= '0;
        vc   <= (vc == VW'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
        bar  <= '0;
        bcnt <= '0;
      end else begin
        hc <= hc + 1'b1;
        if (bcnt == BCW'(BAR_W - 1)) begin
          bcnt <= '0;
          if (bar != 3'd7) bar <= bar + 1'b1;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      lvl      <= '0;
      act_mode <= MODE_BLACK;
    end else if (fs_ev) begin
      phase <= phase + 10'(PHASE_STEP);
      if (mode_e'(mode) != act_mode) begin
        act_mode <= mode_e'(mode);
        lvl      <= '0;
      end else if (lvl != '1) begin
        lvl <= lvl + 1'b1;
      end
    end
  end

  logic               hb_n, vb_n, hs_n, vs_n, de_n;
  logic [9:0]         idx;
  logic [COLOR_W-1:0] band, n, grey;
  logic [2:0]         c;
  logic [COLOR_W-1:0] raw_r, raw_g, raw_b;

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] raw,
                                               input logic [COLOR_W-1:0] lv);
    return COLOR_W'(({{COLOR_W{1'b0}}, raw} * {{COLOR_W{1'b0}}, lv}) >> COLOR_W);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    hb_n  = hblank;
    vb_n  = vblank;
    hs_n  = hs;
    vs_n  = vs;
    raw_r = '0;
    raw_g = '0;
    raw_b = '0;

    // Set wins over clear when START and END coincide.
    if (hc == HW'(HB_START))    hb_n = 1'b1;
    else if (hc == HW'(HB_END)) hb_n = 1'b0;
    if (hc == HW'(HS_START))    hs_n = 1'b1;
    else if (hc == HW'(HS_END)) hs_n = 1'b0;
    if (vc == VW'(VB_START))    vb_n = 1'b1;
    else if (vc == VW'(VB_END)) vb_n = 1'b0;
    if (vc == VW'(VS_START))    vs_n = 1'b1;
    else if (vc == VW'(VS_END)) vs_n = 1'b0;
    de_n = ~hb_n & ~vb_n;

    idx  = phase + (10'(vc) << 2);
    band = {1'b1, (COLOR_W-1)'(triangle(idx) >> (10 - COLOR_W))};
    n    = noise[22 -: COLOR_W];
    grey = (band > n) ? band - n : '0;
    c    = ~bar;

    unique case (act_mode)
      MODE_BLACK: ;
      MODE_BAND: begin
        raw_r = grey;
        raw_g = grey;
        raw_b = grey;
      end
      MODE_BARS: begin
        raw_r = c[2] ? '1 : '0;
        raw_g = c[1] ? '1 : '0;
        raw_b = c[0] ? '1 : '0;
      end
      MODE_NOISE: begin
        raw_r = noise[0 +: COLOR_W];
        raw_g = noise[COLOR_W +: COLOR_W];
        raw_b = noise[2*COLOR_W +: COLOR_W];
      end
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs          <= 1'b0;
      vs          <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hs          <= hs_n;
      vs          <= vs_n;
      hblank      <= hb_n;
      vblank      <= vb_n;
      de          <= de_n;
      frame_start <= fs_ev;
      r           <= de_n ? scale(raw_r, lvl) : '0;
      g           <= de_n ? scale(raw_g, lvl) : '0;
      b           <= de_n ? scale(raw_b, lvl) : '0;
    end
  end

endmodule

// File: tb/tb_idle_screen_gen.sv
// Directed bench for idle_screen_gen on a shrunken 40x10 raster so that long
// fade sequences stay short; outputs are sampled on the falling edge.
module tb_idle_screen_gen;

  localparam int H  = 40;
  localparam int V  = 10;
  localparam int FR = H * V;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       hs, vs, hblank, vblank, de, frame_start;
  logic [5:0] r, g, b;

  int checks = 0;
  int errors = 0;
  int fs_count = 0;

  idle_screen_gen #(
    .H_TOTAL(H), .HB_START(34), .HB_END(38), .HS_START(35), .HS_END(37),
    .V_TOTAL(V), .VB_START(7), .VB_END(1), .VS_START(8), .VS_END(0),
    .COLOR_W(6), .BAR_W(4), .PHASE_STEP(6)
  ) dut (
    .pclk(pclk), .reset(reset), .mode(mode),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  function automatic bit exp_hb(int h); return h >= 34 && h < 38; endfunction
  function automatic bit exp_hs(int h); return h >= 35 && h < 37; endfunction
  function automatic bit exp_vb(int v); return v >= 7 || v < 1;   endfunction
  function automatic bit exp_vs(int v); return v >= 8;            endfunction

  function automatic int band_of(int ph, int v);
    logic [9:0] i;
    logic [8:0] t;
    i = 10'(ph + 4 * v);
    t = i[9] ? ~i[8:0] : i[8:0];
    return 32 + int'(t[8:4]);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    fs_count = 0;
  endtask

  // Steps falling edges until frame_start; returns edges taken or -1 on timeout.
  task automatic wait_fs(output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 2 * FR) begin
      @(negedge pclk);
      cyc++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (found) begin
      fs_count++;
    end else begin
      checks++; errors++;
      $display("FAIL wait_fs: no frame_start within %0d cycles", cyc);
      cyc = -1;
    end
  endtask

  task automatic test_reset();
    int cyc, bad, hs_cnt, de_cnt, fs_cnt;
    reset = 1'b1;
    mode  = 2'd0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({hs, vs, hblank, vblank, de, frame_start, r, g, b} !== {6'b001100, 18'd0}) begin
      errors++;
      $display("FAIL reset_values: got %b/%h%h%h want 001100/000000",
               {hs, vs, hblank, vblank, de, frame_start}, r, g, b);
    end
    do_reset();
    wait_fs(cyc);
    checks++;
    if (cyc != FR + 1) begin
      errors++; $display("FAIL first_frame_start: got %0d cycles want %0d", cyc, FR + 1);
    end
    bad = 0; hs_cnt = 0; de_cnt = 0; fs_cnt = 0;
    for (int p = 0; p < 2 * FR; p++) begin
      int h, v;
      if (p > 0) @(negedge pclk);
      h = p % H; v = (p / H) % V;
      if (hs !== exp_hs(h) || vs !== exp_vs(v) || hblank !== exp_hb(h) ||
          vblank !== exp_vb(v) || de !== (!exp_hb(h) && !exp_vb(v)) ||
          frame_start !== (p % FR == 0)) begin
        if (bad == 0)
          $display("FAIL raster_flags at hc=%0d vc=%0d: hs%b vs%b hb%b vb%b de%b fs%b",
                   h, v, hs, vs, hblank, vblank, de, frame_start);
        bad++;
      end
      hs_cnt += int'(hs);
      de_cnt += int'(de);
      fs_cnt += int'(frame_start);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL raster_flags: %0d bad samples want 0", bad); end
    checks++;
    if (hs_cnt != 2 * 2 * V) begin
      errors++; $display("FAIL hs_count: got %0d want %0d", hs_cnt, 4 * V);
    end
    checks++;
    if (de_cnt != 2 * 36 * 6) begin
      errors++; $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * 36 * 6);
    end
    checks++;
    if (fs_cnt != 2) begin errors++; $display("FAIL fs_count: got %0d want 2", fs_cnt); end
    @(negedge pclk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL frame_period: frame_start=%b want 1 after %0d cycles", frame_start, FR);
    end
    fs_count += 3;
  endtask

  task automatic test_mode_sync();
    int cyc, nz, pos, e;
    repeat (4 * H) @(negedge pclk);
    mode = 2'd2;
    nz = 0; pos = 4 * H;
    while (frame_start !== 1'b1 && pos < 2 * FR) begin
      @(negedge pclk);
      pos++;
      if (frame_start !== 1'b1 && {r, g, b} !== 18'd0) nz++;
    end
    checks++;
    if (pos != FR || nz != 0) begin
      errors++; $display("FAIL mode_sync_hold: %0d nonzero px, frame end at %0d want 0/%0d", nz, pos, FR);
    end
    fs_count++;
    for (int k = 0; k <= 64; k++) begin
      repeat (2 * H + 2) @(negedge pclk);
      e = (63 * (k > 63 ? 63 : k)) >> 6;
      checks++;
      if (r !== 6'(e) || g !== 6'(e) || b !== 6'(e)) begin
        errors++; $display("FAIL fade_bar0 frame %0d: got %0d/%0d/%0d want %0d", k, r, g, b, e);
      end
      wait_fs(cyc);
    end
  endtask

  task automatic test_bars();
    int cyc;
    repeat (3 * H) @(negedge pclk);
    for (int h = 0; h < H; h++) begin
      logic [2:0] bar, c;
      logic [17:0] e;
      if (h > 0) @(negedge pclk);
      bar = (h / 4 > 7) ? 3'd7 : 3'(h / 4);
      c = ~bar;
      e = {c[2] ? 6'd62 : 6'd0, c[1] ? 6'd62 : 6'd0, c[0] ? 6'd62 : 6'd0};
      if (exp_hb(h)) e = '0;
      checks++;
      if ({r, g, b} !== e) begin
        errors++; $display("FAIL bars hc=%0d: got %h want %h", h, {r, g, b}, e);
      end
    end
    wait_fs(cyc);
  endtask

  task automatic test_band();
    int cyc, e, lv;
    force dut.noise = 23'h0;
    mode = 2'd1;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      wait_fs(cyc);
      repeat (2 * H + 2) @(negedge pclk);
      lv = fs_count - 1;
      e = (band_of(6 * fs_count, 2) * lv) >> 6;
      checks++;
      if (r !== 6'(e) || g !== 6'(e) || b !== 6'(e)) begin
        errors++; $display("FAIL band frame %0d: got %0d/%0d/%0d want %0d", k, r, g, b, e);
      end
      if (k == 10) begin
        checks++;
        if (r !== 6'd5) begin errors++; $display("FAIL band_phase60: got %0d want 5", r); end
      end
    end
    wait_fs(cyc);
  endtask

  task automatic test_saturation();
    int cyc, nz, e;
    force dut.noise = 23'h7F_FFFF;
    repeat (3 * H) @(negedge pclk);
    nz = 0;
    for (int h = 0; h < H; h++) begin
      @(negedge pclk);
      if ({r, g, b} !== 18'd0) nz++;
    end
    checks++;
    if (nz != 0) begin errors++; $display("FAIL band_saturate: %0d nonzero px want 0", nz); end
    force dut.noise = 23'h28_0000;
    wait_fs(cyc);
    repeat (3 * H + 2) @(negedge pclk);
    e = ((band_of(6 * fs_count, 3) - 20) * (fs_count - 1)) >> 6;
    checks++;
    if (r !== 6'(e) || g !== 6'(e) || b !== 6'(e)) begin
      errors++; $display("FAIL band_minus_n: got %0d/%0d/%0d want %0d", r, g, b, e);
    end
  endtask

  task automatic test_noise();
    int cyc;
    logic [22:0] nv;
    logic [5:0] nr, ng, nb;
    nv = 23'h1A_B5E7;
    nr = nv[5:0]; ng = nv[11:6]; nb = nv[17:12];
    force dut.noise = nv;
    mode = 2'd3;
    wait_fs(cyc);
    for (int j = 0; j <= 20; j++) begin
      repeat (2 * H + 2) @(negedge pclk);
      checks++;
      if (r !== 6'((nr * j) >> 6) || g !== 6'((ng * j) >> 6) || b !== 6'((nb * j) >> 6)) begin
        errors++;
        $display("FAIL noise frame %0d: got %0d/%0d/%0d want %0d/%0d/%0d", j, r, g, b,
                 (nr * j) >> 6, (ng * j) >> 6, (nb * j) >> 6);
      end
      if (j == 20) begin
        repeat (33) @(negedge pclk);
        checks++;
        if ({de, r, g, b} !== 19'd0) begin
          errors++; $display("FAIL blank_rgb hc=35: de=%b rgb=%h want 0", de, {r, g, b});
        end
      end
      wait_fs(cyc);
    end
    release dut.noise;
  endtask

  task automatic test_midframe_reset();
    int cyc;
    repeat (5 * H + 25) @(negedge pclk);
    checks++;
    if (de !== 1'b1 || r === 6'd0) begin
      errors++; $display("FAIL pre_reset_active: de=%b r=%0d want de=1 r>0", de, r);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({hs, vs, hblank, vblank, de, frame_start, r, g, b} !== {6'b001100, 18'd0}) begin
      errors++;
      $display("FAIL midframe_reset: got %b/%h%h%h want 001100/000000",
               {hs, vs, hblank, vblank, de, frame_start}, r, g, b);
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    fs_count = 0;
    wait_fs(cyc);
    checks++;
    if (cyc != FR + 1) begin
      errors++; $display("FAIL resume_frame_start: got %0d cycles want %0d", cyc, FR + 1);
    end
  endtask

  initial begin
    test_reset();
    test_mode_sync();
    test_bars();
    test_band();
    test_saturation();
    test_noise();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
